port_requester: RTL and testbench

PORT_REQUESTER -- requirements
Module: port_requester

---
 rtl/port_requester_if.sv | 27 ++
 rtl/port_requester.sv | 124 ++++++++++++
 tb/tb_port_requester.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/port_requester_if.sv
// rtl/port_requester_if.sv - upstream, arbiter and crossbar signals of one input port
interface port_requester_if #(
  parameter int DW = 8
);
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          in_head;
  logic          in_tail;
  logic [4:0]    req;
  logic [4:0]    grt;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          out_head;
  logic          out_tail;
  logic          out_rdy;

  modport master (
    input  in_vld, in_data, in_head, in_tail, grt, out_rdy,
    output in_rdy, req, out_vld, out_data, out_head, out_tail
  );

  modport slave (
    output in_vld, in_data, in_head, in_tail, grt, out_rdy,
    input  in_rdy, req, out_vld, out_data, out_head, out_tail
  );
endinterface

// File: rtl/port_requester.sv
// rtl/port_requester.sv - input FIFO plus request FSM for one router input port
// REQ_DROP_CNT_EN adds a saturating drop_cnt output counting dropped packets.
module port_requester #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic clk,
  input  logic rst_,
  port_requester_if.master bus
`ifdef REQ_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 2;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, push, pop;
  logic [EW-1:0] hd;
  logic          hd_head, hd_tail, dest_ok, gnt, out_vld;
  logic [DW-1:0] hd_data;
  state_t        state, nxt;
  logic [2:0]    dest, dest_nxt;
  logic [4:0]    req_q, req_nxt;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push  = bus.in_vld && !full;

  assign hd      = mem[rptr[AW-1:0]];
  assign hd_head = hd[EW-1];
  assign hd_tail = hd[EW-2];
  assign hd_data = hd[DW-1:0];
  assign dest_ok = (hd_data[2:0] <= 3'd4);
  assign gnt     = bus.grt[dest];

  assign bus.in_rdy   = !full;
  assign bus.out_data = hd_data;
  assign bus.out_head = hd_head;
  assign bus.out_tail = hd_tail;
  assign bus.out_vld  = out_vld;
  assign bus.req      = req_q;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {bus.in_head, bus.in_tail, bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state <= IDLE;
      req_q <= '0;
      dest  <= '0;
    end else begin
      state <= nxt;
      req_q <= req_nxt;
      dest  <= dest_nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (!empty && hd_head) nxt = dest_ok ? REQ : DROP;
      REQ:  if (gnt) nxt = XFER;
      XFER: if (pop && hd_tail) nxt = IDLE;
      DROP: if (pop && hd_tail) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    out_vld  = 1'b0;
    pop      = 1'b0;
    req_nxt  = req_q;
    dest_nxt = dest;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!hd_head) begin
            pop = 1'b1;
          end else if (dest_ok) begin
            dest_nxt = hd_data[2:0];
            req_nxt  = 5'(1) << hd_data[2:0];
          end
        end
      end
      XFER: begin
        out_vld = !empty && gnt;
        pop     = out_vld && bus.out_rdy;
        // Dropping req with the tail guarantees an idle request cycle between packets.
        if (pop && hd_tail) req_nxt = '0;
      end
      DROP: pop = !empty;
      default: ;
    endcase
  end

`ifdef REQ_DROP_CNT_EN
  logic drop_start;
  assign drop_start = (state == IDLE) && (nxt == DROP);

  always_ff @(posedge clk) begin
    if (rst_) drop_cnt <= '0;
    else if (drop_start && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_port_requester.sv
// tb/tb_port_requester.sv - scoreboard bench for port_requester, directed plus random packets
module tb_port_requester;

  typedef struct packed {
    logic       head;
    logic       tail;
    logic [7:0] data;
    logic [2:0] dest;
    logic       fwd;
  } flit_t;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  port_requester_if #(.DW(8)) bus ();
`ifdef REQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  port_requester #(.DEPTH(4), .DW(8)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.master)
`ifdef REQ_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  flit_t stim[$];
  flit_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    n_drop_model = 0;
  logic  mon_gap = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endfunction

  function automatic flit_t mk(logic h, logic t, logic [7:0] d, logic [2:0] dst, logic fwd);
    flit_t f;
    f.head = h; f.tail = t; f.data = d; f.dest = dst; f.fwd = fwd;
    return f;
  endfunction

  // One clock of stimulus; returns at the falling edge with acceptance known.
  task automatic cycle(input logic v, input flit_t f, input logic [4:0] g, input logic r,
                       output logic acc);
    @(posedge clk);
    #1;
    bus.in_vld  = v;
    bus.in_head = f.head;
    bus.in_tail = f.tail;
    bus.in_data = f.data;
    bus.grt     = g;
    bus.out_rdy = r;
    @(negedge clk);
    acc = v && bus.in_rdy;
    if (acc && f.fwd) exp_q.push_back(f);
  endtask

  // Monitor: every transferred flit must match the oldest forwarded flit.
  initial begin
    flit_t e;
    forever begin
      @(negedge clk);
      if (rst_) begin
        mon_gap = 1'b0;
      end else begin
        if (mon_gap) begin
          chk("req_gap", 32'(bus.req), 32'd0);
          mon_gap = 1'b0;
        end
        if (bus.out_vld) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_out: got flit %0h expected none", bus.out_data);
          end else begin
            e = exp_q[0];
            chk("out_grt", 32'(bus.grt[e.dest]), 32'd1);
            chk("req_onehot", 32'(bus.req), 32'd1 << e.dest);
            if (bus.out_rdy) begin
              e = exp_q.pop_front();
              chk("out_flit", {22'd0, bus.out_head, bus.out_tail, bus.out_data},
                  {22'd0, e.head, e.tail, e.data});
              if (e.tail) mon_gap = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    flit_t nf, cur;
    logic  acc, have;
    logic [4:0] g;
    int len;
    logic [2:0] dst;
    nf = mk(0, 0, 8'h00, 3'd0, 0);
    bus.in_vld = 0; bus.in_head = 0; bus.in_tail = 0; bus.in_data = 0;
    bus.grt = 0; bus.out_rdy = 0;

    cycle(0, nf, 5'd0, 1, acc);
    cycle(0, nf, 5'd0, 1, acc);
    rst_ = 1'b0;
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);

    // Four-flit packet to port 3, latency and foreign-grant checks
    cycle(1, mk(1, 0, 8'h03, 3'd3, 1), 5'd0, 1, acc);
    chk("push_acc", 32'(acc), 32'd1);
    cycle(1, mk(0, 0, 8'hA5, 3'd3, 1), 5'd0, 1, acc);
    chk("req_lat_n1", 32'(bus.req), 32'd0);
    cycle(1, mk(0, 0, 8'h5A, 3'd3, 1), 5'd0, 1, acc);
    chk("req_lat_n2", 32'(bus.req), 32'b01000);
    cycle(1, mk(0, 1, 8'h3C, 3'd3, 1), 5'b10111, 1, acc);
    chk("req_other_grt", 32'(bus.out_vld), 32'd0);
    cycle(0, nf, 5'b01000, 1, acc);
    chk("req_state_no_out", 32'(bus.out_vld), 32'd0);
    cycle(0, nf, 5'b01000, 1, acc);
    chk("first_out_lat", 32'(bus.out_vld), 32'd1);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle(0, nf, 5'b01000, 1, acc);
    chk("drain_pkt3", 32'(exp_q.size()), 32'd0);
    cycle(0, nf, 5'b01000, 1, acc);
    chk("req_after_tail", 32'(bus.req), 32'd0);

    // Packet to invalid port 6 is dropped
    cycle(1, mk(1, 0, 8'h06, 3'd6, 0), 5'h1f, 1, acc);
    cycle(1, mk(0, 1, 8'h77, 3'd6, 0), 5'h1f, 1, acc);
    n_drop_model++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, nf, 5'h1f, 1, acc);
      chk("drop_no_req", 32'(bus.req), 32'd0);
    end
`ifdef REQ_DROP_CNT_EN
    chk("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif

    // Single-flit packet to port 1
    cycle(1, mk(1, 1, 8'h01, 3'd1, 1), 5'b00010, 1, acc);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(0, nf, 5'b00010, 1, acc);
    chk("drain_single", 32'(exp_q.size()), 32'd0);

    // Fill FIFO with crossbar stalled, then reset mid-packet
    cycle(1, mk(1, 0, 8'h02, 3'd2, 1), 5'd0, 0, acc);
    cycle(1, mk(0, 0, 8'h11, 3'd2, 1), 5'd0, 0, acc);
    cycle(1, mk(0, 0, 8'h22, 3'd2, 1), 5'd0, 0, acc);
    cycle(1, mk(0, 1, 8'h33, 3'd2, 1), 5'd0, 0, acc);
    cycle(0, nf, 5'd0, 0, acc);
    chk("full_in_rdy", 32'(bus.in_rdy), 32'd0);
    rst_ = 1'b1;
    cycle(0, nf, 5'd0, 0, acc);
    exp_q.delete();
    rst_ = 1'b0;
    cycle(0, nf, 5'h1f, 1, acc);
    chk("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("mid_rst_out_vld", 32'(bus.out_vld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, nf, 5'h1f, 1, acc);
      chk("mid_rst_req", 32'(bus.req), 32'd0);
    end
    n_drop_model = 0;

    // Random packets with orphans, drops, bubbles and grant/ready stalls
    for (int p = 0; p < 120; p++) begin
      if ($urandom_range(0, 9) == 0)
        stim.push_back(mk(0, 1'($urandom_range(0, 1)), 8'($urandom), 3'd0, 0));
      len = $urandom_range(1, 4);
      dst = 3'($urandom_range(0, 7));
      if (dst > 3'd4) n_drop_model++;
      for (int i = 0; i < len; i++)
        stim.push_back(mk(i == 0, i == len - 1,
                          (i == 0) ? {5'($urandom), dst} : 8'($urandom), dst, dst <= 3'd4));
    end
    have = 1'b0;
    cur = nf;
    for (int c = 0; c < 20000 && (stim.size() > 0 || have || exp_q.size() > 0); c++) begin
      if (!have && stim.size() > 0 && $urandom_range(0, 3) != 0) begin
        cur = stim.pop_front();
        have = 1'b1;
      end
      g = ($urandom_range(0, 2) != 0) ? 5'h1f : 5'($urandom_range(0, 31));
      cycle(have, cur, g, $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    chk("rand_stim_done", 32'(stim.size()), 32'd0);
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 10; i++) cycle(0, nf, 5'h1f, 1, acc);
    chk("final_req_idle", 32'(bus.req), 32'd0);
`ifdef REQ_DROP_CNT_EN
    chk("rand_drop_cnt", 32'(drop_cnt), 32'(n_drop_model > 255 ? 255 : n_drop_model));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
